// File: rtl/baud_cfg_sequencer.sv
// Baud-divisor programming controller: arbitrates CPU vs. preset requests, writes the
// divisor byte-wise into the baud generator and waits for the first tick at the new rate.
module baud_cfg_sequencer #(
    parameter int DIV0    = 651,
    parameter int DIV1    = 326,
    parameter int DIV2    = 163,
    parameter int DIV3    = 81,
    parameter int TIMEOUT = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_div,
    input  logic        preset_req,
    input  logic [1:0]  preset_sel,
    input  logic        baud_tick,
    output logic        cpu_ack,
    output logic        preset_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cfg_hold,
    output logic [15:0] cur_div,
    output logic        baud_write_en,
    output logic        baud_write_location,
    output logic [7:0]  baud_generator_write_line
);

    typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, SETTLE, FIN} state_t;

    localparam logic [17:0] SETTLE_LAST = 18'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] div_q;
    logic [17:0] settle_cnt;
    logic        last_cpu;     // 1 = CPU won the previous grant

    logic        grant_any;
    logic        grant_cpu;
    logic [15:0] preset_div;
    logic [15:0] req_div;

    // Round-robin: a lone request wins; on a tie the side not served last time wins.
    assign grant_any = cpu_req | preset_req;
    assign grant_cpu = cpu_req & (~preset_req | ~last_cpu);
    assign req_div   = grant_cpu ? cpu_div : preset_div;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves preset_div unassigned (no latch).
        preset_div = 16'(DIV1);
        case (preset_sel)
            2'd0:    preset_div = 16'(DIV0);
            2'd1:    preset_div = 16'(DIV1);
            2'd2:    preset_div = 16'(DIV2);
            default: preset_div = 16'(DIV3);
        endcase
    end

    // NOTE: all state and outputs are updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            div_q                     <= '0;
            settle_cnt                <= '0;
            last_cpu                  <= 1'b0;
            cpu_ack                   <= 1'b0;
            preset_ack                <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            err                       <= 1'b0;
            cfg_hold                  <= 1'b0;
            cur_div                   <= 16'(DIV1);
            baud_write_en             <= 1'b0;
            baud_write_location       <= 1'b0;
            baud_generator_write_line <= 8'h00;
        end else begin
            cpu_ack                   <= 1'b0;
            preset_ack                <= 1'b0;
            done                      <= 1'b0;
            err                       <= 1'b0;
            baud_write_en             <= 1'b0;
            baud_write_location       <= 1'b0;
            baud_generator_write_line <= 8'h00;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_cpu   <= grant_cpu;
                        cpu_ack    <= grant_cpu;
                        preset_ack <= ~grant_cpu;
                        div_q      <= req_div;
                        busy       <= 1'b1;
                        cfg_hold   <= 1'b1;
                        if (req_div == 16'd0) begin
                            // A zero divisor would stall the generator; reject without writing.
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state                     <= WR_LO;
                            baud_write_en             <= 1'b1;
                            baud_generator_write_line <= req_div[7:0];
                        end
                    end
                end

                WR_LO: begin
                    state                     <= WR_HI;
                    baud_write_en             <= 1'b1;
                    baud_write_location       <= 1'b1;
                    baud_generator_write_line <= div_q[15:8];
                end

                WR_HI: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                end

                SETTLE: begin
                    if (baud_tick) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 18'd1;
                    end
                end

                FIN: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cfg_hold <= 1'b0;
                    if (!err) cur_div <= div_q;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/baud_cfg_sequencer.md
# baud_cfg_sequencer

Controller that programs the SPART baud-rate divisor. It arbitrates between two requesters: a processor-side direct divisor write and a preset select from board switches. For the granted request it issues the byte-wise DB-low/DB-high write sequence into the baud generator, then waits for the first baud tick under the new setting. Throughout reconfiguration it holds the transmit and receive engines off via `cfg_hold`.

## Interface
- `DIV0`, default 651, preset divisor for select 0 (4800 bps @ 50 MHz)
- `DIV1`, default 326, preset divisor for select 1 (9600 bps); also the reset value of `cur_div`
- `DIV2`, default 163, preset divisor for select 2 (19200 bps)
- `DIV3`, default 81, preset divisor for select 3 (38400 bps)
- `TIMEOUT`, default 131072, settle-wait limit in cycles (≥ 2×65536)

- `clk` in 1: system clock
- `rst_n` in 1: asynchronous active-low reset
- `cpu_req` in 1: level request, held until `cpu_ack`
- `cpu_div` in 16: divisor for the CPU request, sampled on grant
- `preset_req` in 1: level request, held until `preset_ack`
- `preset_sel` in 2: preset index, sampled on grant
- `baud_tick` in 1: tick from the baud generator (its transmit enable)
- `cpu_ack` out 1: 1-cycle grant pulse
- `preset_ack` out 1: 1-cycle grant pulse
- `busy` out 1: sequence in progress
- `done` out 1: 1-cycle completion pulse
- `err` out 1: 1-cycle pulse, coincident with `done`, on a rejected or timed-out sequence
- `cfg_hold` out 1: stall for the TX/RX engines
- `cur_div` out 16: last successfully programmed divisor
- `baud_write_en` out 1: to baud generator
- `baud_write_location` out 1: 0 = DB low, 1 = DB high
- `baud_generator_write_line` out 8: write data byte

## Operation
- FSM states: IDLE, WR_LO, WR_HI, SETTLE, FIN.
- IDLE, no request pending: stay.
- IDLE, request pending:
  - Arbitrate and grant.
  - Latch `div_q` (`cpu_div`, or `DIVn` selected by `preset_sel`).
  - Pulse the matching ack.
  - If `div_q` is 0, go to FIN with the error flag set (no writes).
  - Otherwise go to WR_LO.
- Arbitration is round-robin:
  - If only one request is high, it wins.
  - If both are high, the source not granted last time wins.
  - The last-granted flag resets to "preset", so CPU wins the first tie.
- WR_LO: `baud_write_en`=1, `baud_write_location`=0, line=`div_q[7:0]`; then go to WR_HI.
- WR_HI: `baud_write_en`=1, `baud_write_location`=1, line=`div_q[15:8]`; then go to SETTLE, with the 18-bit settle counter cleared.
- SETTLE:
  - On `baud_tick`=1, go to FIN (success).
  - When the counter reaches `TIMEOUT`-1 with no tick, go to FIN with the error flag set.
  - Otherwise increment the counter.
- FIN:
  - `done`=1; `err`=error flag.
  - On success, `cur_div` ← `div_q` at the FIN→IDLE edge. On error, `cur_div` is unchanged.
  - Next state: IDLE.
- Requests arriving while not in IDLE are not acked. Requesters keep them asserted and they are served after FIN.
- Reset values:
  - `cpu_ack`, `preset_ack`, `busy`, `done`, `err`, `cfg_hold`, `baud_write_en`, `baud_write_location` = 0
  - `baud_generator_write_line` = 0x00
  - `cur_div` = `DIV1`
  - FSM = IDLE, settle counter = 0, `div_q` = 0
- Asserting reset mid-sequence aborts immediately to the reset state. No ack, done or write is issued afterwards. A partially written divisor is not tracked, and `cur_div` returns to `DIV1`, matching the generator's own reset default.

## Timing
- All outputs are registered or decoded only from registered state. There is no combinational input→output path.
- Request seen high at edge E (FSM in IDLE):
  - Ack is high for cycle E+1.
  - `busy` and `cfg_hold` rise at E+1.
  - WR_LO occupies cycle E+1; WR_HI occupies cycle E+2; SETTLE starts at E+3.
- A tick sampled in SETTLE at edge T gives FIN (`done`) in cycle T+1. `busy` and `cfg_hold` drop at T+2.
- Minimum successful latency: 4 cycles from grant to `done`, given a tick in the first SETTLE cycle.
- Zero-divisor path: grant at E, FIN in cycle E+1 (`done`=`err`=1, no `baud_write_en`), IDLE at E+2.
- `baud_tick` is ignored outside SETTLE, including during WR_LO/WR_HI.
- `busy` and `cfg_hold` are high in every non-IDLE state, FIN included.
- Back-to-back requests: the earliest next grant is the cycle after FIN, so acks are at least 5 cycles apart.

## Test plan
- Reset: hold `rst_n`=0, wiggle all inputs → all outputs at their reset values and `cur_div`=326. Release → IDLE, no ack.
- `preset_req`=1, `preset_sel`=2, tick 10 cycles after WR_HI:
  - `preset_ack` 1 cycle.
  - Writes: (loc 0, 0xA3), then (loc 1, 0x00) on consecutive cycles.
  - `done`=1, `err`=0, `cur_div`=163.
- `cpu_req` and `preset_req` high together (`cpu_div`=0x028B, `preset_sel`=0), both held:
  - CPU served first with writes 0x8B, 0x02.
  - Preset served next with writes 0x8B, 0x02 (651).
  - A third tie, with CPU re-asserted, goes to CPU.
- `cpu_div`=0 → `cpu_ack`, then `done`=`err`=1 the next cycle. `baud_write_en` never asserts and `cur_div` is unchanged.
- `baud_tick` held 0 after WR_HI → `done`=`err`=1 exactly `TIMEOUT` cycles after entering SETTLE; `cur_div` unchanged.
- Assert `rst_n`=0 during WR_HI → outputs return to reset values in the same cycle, and no `done` follows after release.
